// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: initiator side of the registered arithmetic-unit interface.
// Accepts one request at a time, issues it to the unit for a single cycle,
// captures the unit's registered result one cycle later and returns it on a
// valid/ready response channel. Divide-by-zero is answered without using the
// unit. op_count counts delivered responses, including error responses.
module alu_op_sequencer #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 16
) (
  input  logic             Clk,
  input  logic             RST,
  // request channel
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic [1:0]       req_fun,
  // response channel
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_carry,
  output logic             rsp_err,
  // arithmetic unit side
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [1:0]       alu_fun,
  output logic             alu_enable,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_carry,
  input  logic             alu_flag,
  // status
  output logic             busy,
  output logic [CNT_W-1:0] op_count
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2,
    RESP    = 2'd3
  } state_t;

  localparam logic [1:0] FUN_ADD = 2'b00;
  localparam logic [1:0] FUN_SUB = 2'b01;
  localparam logic [1:0] FUN_DIV = 2'b11;

  state_t state;

  // Local copy of the accepted operands; kept separate from the unit-facing
  // registers so the borrow decision never depends on what is driven out.
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [1:0]       op_fun;

  // Carry reported to the consumer: unit carry for add, local borrow for sub,
  // zero for mul/div.
  logic carry_sel;
  assign carry_sel = (op_fun == FUN_ADD) ? alu_carry :
                     (op_fun == FUN_SUB) ? (op_a < op_b) : 1'b0;

  // Sequencer FSM; every output is a register updated on the transition into
  // the state that owns it, so no output depends combinationally on inputs.
  always_ff @(posedge Clk) begin
    // NOTE: all state here uses <= so every register samples pre-edge values;
    // a blocking assignment would let later lines see this cycle's updates.
    if (RST) begin
      state      <= IDLE;
      req_ready  <= 1'b1;
      rsp_valid  <= 1'b0;
      rsp_result <= '0;
      rsp_carry  <= 1'b0;
      rsp_err    <= 1'b0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_fun    <= '0;
      alu_enable <= 1'b0;
      busy       <= 1'b0;
      op_count   <= '0;
      op_a       <= '0;
      op_b       <= '0;
      op_fun     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            alu_a     <= req_a;
            alu_b     <= req_b;
            alu_fun   <= req_fun;
            op_a      <= req_a;
            op_b      <= req_b;
            op_fun    <= req_fun;
            req_ready <= 1'b0;
            busy      <= 1'b1;
            if (req_fun == FUN_DIV && req_b == '0) begin
              // Divide-by-zero: answer immediately, the unit is never enabled.
              rsp_result <= '0;
              rsp_carry  <= 1'b0;
              rsp_err    <= 1'b1;
              rsp_valid  <= 1'b1;
              state      <= RESP;
            end else begin
              alu_enable <= 1'b1;
              state      <= ISSUE;
            end
          end
        end

        ISSUE: begin
          // The unit registers its result on this edge.
          alu_enable <= 1'b0;
          state      <= CAPTURE;
        end

        CAPTURE: begin
          rsp_result <= alu_out;
          rsp_carry  <= carry_sel;
          rsp_err    <= ~alu_flag;
          rsp_valid  <= 1'b1;
          state      <= RESP;
        end

        RESP: begin
          // Response held indefinitely until the consumer takes it.
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            busy      <= 1'b0;
            op_count  <= op_count + CNT_W'(1);
            state     <= IDLE;
          end
        end

        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule
